apb_master_cmd: RTL and testbench

Parametrised, command-driven APB4 requester; successor to the free-running fixed-address APB master.
- Accepts one read or write per valid/ready command handshake.
- Runs the APB SETUP/ACCESS protocol and returns read data plus error status on a buffered valid/ready response channel.
- Sits between an internal requester (CPU stub, DMA, test sequencer) and a single APB slave or APB decoder.

---
 rtl/apb_master_cmd.sv | 167 ++++++++++++++++
 tb/tb_apb_master_cmd.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_cmd.sv
// apb_master_cmd: command-driven APB4 requester.
// One read/write per cmd valid/ready handshake, IDLE -> SETUP -> ACCESS -> RESP,
// with a buffered valid/ready response channel (rdata, err, timeout).
// Optional build macro APB_TIMEOUT_EN: aborts ACCESS after TIMEOUT pready-low
// cycles and reports rsp_err_o = rsp_timeout_o = 1. Without it ACCESS waits
// indefinitely and rsp_timeout_o is tied low.
module apb_master_cmd #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [STRB_W-1:0] cmd_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic [STRB_W-1:0] pstrb_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    // Reject unsupported data widths and a zero timeout at elaboration.
    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32) || TIMEOUT < 1) begin : g_param_check
        $error("apb_master_cmd: DATA_W must be 8/16/32 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;   // command handshake this cycle
    logic   done;     // slave completed the access this cycle

    // Control outputs decode straight from the state register, so the async
    // reset drops psel/penable/rsp_valid immediately and nothing is
    // combinational from the APB inputs.
    assign cmd_ready_o = (state == IDLE);
    assign psel_o      = (state == SETUP) || (state == ACCESS);
    assign penable_o   = (state == ACCESS);
    assign rsp_valid_o = (state == RESP);

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;
    logic             abort;
    logic             timeout_q;

    assign rsp_timeout_o = timeout_q;

    // Wait-state counter: cleared while in SETUP, counts pready-low ACCESS cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready_i && !abort) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign rsp_timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; pready wins over the timeout limit on the same cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
`ifdef APB_TIMEOUT_EN
        abort     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt == LIMIT) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // APB request registers load on accept; response registers load on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                pwrite_o <= cmd_write_i;
                paddr_o  <= cmd_addr_i;
                if (cmd_write_i) begin
                    pwdata_o <= cmd_wdata_i;
                    pstrb_o  <= cmd_strb_i;
                end else begin
                    // Reads keep the previous write data on the bus.
                    pstrb_o  <= '0;
                end
            end
            if (done) begin
                rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                rsp_err_o   <= pslverr_i;
`ifdef APB_TIMEOUT_EN
                timeout_q   <= 1'b0;
`endif
            end
`ifdef APB_TIMEOUT_EN
            if (abort) begin
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b1;
                timeout_q   <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_cmd.sv
// Directed, table-driven bench for apb_master_cmd (TIMEOUT=4 for the optional
// APB_TIMEOUT_EN build) plus hand-written multi-cycle sequences.
module tb_apb_master_cmd;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    int total = 0;
    int bad   = 0;

    apb_master_cmd #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
        .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting in IDLE, rsp_ready held high.
    task automatic run_vec(input vec_t v);
        rsp_ready = 1'b1;
        check("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        pready = 1'b0; pslverr = 1'b0;
        step();
        // SETUP: cmd inputs perturbed to prove the bus is registered
        cmd_valid = 1'b0; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        check("setup_sel_en", {psel, penable}, 2'b10);
        check("setup_paddr", paddr, v.addr);
        check("setup_pwrite", pwrite, v.write);
        check("setup_pwdata", pwdata, v.exp_pwdata);
        check("setup_pstrb", pstrb, v.exp_pstrb);
        check("setup_cmd_ready", cmd_ready, 0);
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;  // ignored in SETUP
        step();
        for (int k = 0; k <= v.waits; k++) begin
            check("access_sel_en", {psel, penable}, 2'b11);
            check("access_paddr", paddr, v.addr);
            check("access_pwdata", pwdata, v.exp_pwdata);
            check("access_pstrb", pstrb, v.exp_pstrb);
            check("access_rsp_valid", rsp_valid, 0);
            if (k == v.waits) begin
                pready = 1'b1; prdata = v.prdata; pslverr = v.err;
            end else begin
                pready = 1'b0; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
            end
            step();
        end
        pready = 1'b0; pslverr = 1'b0;
        check("resp_valid", rsp_valid, 1);
        check("resp_rdata", rsp_rdata, v.exp_rdata);
        check("resp_err", rsp_err, v.exp_err);
        check("resp_timeout", rsp_timeout, 0);
        check("resp_sel_en", {psel, penable}, 2'b00);
        check("resp_cmd_ready", cmd_ready, 0);
        step();
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_addr[3];
        vec_t        v;
        int          nxt;
        int          kk;

        //          write addr          wdata         strb waits prdata        err exp_rdata     exp_err exp_pwdata    exp_pstrb
        vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_CAFE, 4'hF, 0, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_CAFE, 4'hF};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 32'hDEAD_CAFE, 4'h0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_00A5, 4'h1, 1, 32'h9999_9999, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_00A5, 4'h1};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_00A5, 4'h0};
        vecs[4] = '{1'b1, 32'h2000_0004, 32'h1111_2222, 4'h6, 2, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h1111_2222, 4'h6};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h1111_2222, 4'h0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b1;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        #12;
        check("rst_psel_pen", {psel, penable}, 2'b00);
        check("rst_bus", {pwrite, paddr, pstrb}, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef APB_TIMEOUT_EN
        // Timeout abort: pready never rises; 4 counted waits then abort on the 5th ACCESS cycle.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
        step();
        cmd_valid = 1'b0; pready = 1'b0; prdata = 32'hFFFF_FFFF;
        step();
        for (int k = 0; k < 5; k++) begin
            check("to_access", {psel, penable}, 2'b11);
            step();
        end
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_flags", {rsp_err, rsp_timeout}, 2'b11);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_sel_en", {psel, penable}, 2'b00);
        step();
        check("to_idle", cmd_ready, 1);
        // pready on the limit cycle completes normally
        v = '{1'b0, 32'h54, 32'h0, 4'h0, 4, 32'h7777_8888, 1'b0, 32'h7777_8888, 1'b0, 32'h1111_2222, 4'h0};
        run_vec(v);
`endif

        // Slave error plus 5 cycles of response back-pressure, next cmd waiting.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        step();
        cmd_valid = 1'b0; pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_A5A5;
        step();
        check("bp_access", {psel, penable}, 2'b11);
        step();
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h77; cmd_strb = 4'h3;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_err", rsp_err, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_psel", psel, 0);
            step();
        end
        check("bp_rsp_valid_last", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        check("bp_idle_ready", cmd_ready, 1);
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_err_hold", rsp_err, 1);
        check("bp_rdata_hold", rsp_rdata, 32'hA5A5_A5A5);
        step();
        check("bp_next_setup", {psel, penable}, 2'b10);
        check("bp_next_bus", {pwrite, paddr, pstrb}, {1'b1, 32'h30, 4'h3});
        check("bp_next_wdata", pwdata, 32'h77);
        cmd_valid = 1'b0; pready = 1'b1;
        step();
        step();
        check("bp_next_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("bp_next_rdata", rsp_rdata, 0);
        pready = 1'b0;
        step();

        // Back-to-back reads, cmd_valid held, rsp_ready and pready high: 4-cycle period.
        b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h104; b2b_addr[2] = 32'h108;
        rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0; cmd_write = 1'b0;
        for (int c = 0; c < 12; c++) begin
            kk  = c / 4;
            nxt = (c % 4 == 0) ? kk : kk + 1;
            cmd_valid = (nxt < 3);
            cmd_addr  = (nxt < 3) ? b2b_addr[nxt] : 32'h0;
            prdata    = {16'hC0DE, b2b_addr[kk][15:0]};
            check("b2b_cmd_ready", cmd_ready, (c % 4 == 0));
            check("b2b_psel", psel, (c % 4 == 1) || (c % 4 == 2));
            if (c % 4 == 1) check("b2b_paddr", paddr, b2b_addr[kk]);
            if (c % 4 == 3) begin
                check("b2b_rsp_valid", rsp_valid, 1);
                check("b2b_rsp_rdata", rsp_rdata, {16'hC0DE, b2b_addr[kk][15:0]});
            end
            step();
        end
        check("b2b_end_idle", {cmd_ready, psel}, 2'b10);
        pready = 1'b0;

        // Reset asserted mid-ACCESS drops the bus asynchronously.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("rm_access", {psel, penable}, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        check("rm_sel_en", {psel, penable}, 2'b00);
        check("rm_rsp_valid", rsp_valid, 0);
        check("rm_cmd_ready", cmd_ready, 1);
        check("rm_paddr", paddr, 0);
        #2 reset_n = 1'b1;
        step();
        v = '{1'b0, 32'h60, 32'h0, 4'h0, 0, 32'h600D_D00D, 1'b0, 32'h600D_D00D, 1'b0, 32'h0, 4'h0};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
